// File: rtl/tester_gtx_pkg.sv
// tester_gtx_pkg: constants, K-flag encodings and FSM states shared by the GTX link pattern generator and checker.
package tester_gtx_pkg;
  localparam logic [15:0] IDLE_WORD = 16'h02bc;
  localparam logic [1:0] K_IDLE = 2'b01;
  localparam logic [1:0] K_DATA = 2'b00;
  localparam int BURST_LEN_DEF = 32;
  localparam int LOCK_BURSTS_DEF = 4;
  typedef enum logic [1:0] {ST_UNLOCK, ST_SYNC, ST_IDLE, ST_DATA} gtx_st_t;
endpackage

// File: rtl/tester_gtx_sat_cnt.sv
// tester_gtx_sat_cnt: W-bit counter, increment by 0/1/2, saturating or wrapping, with synchronous clear that wins.
module tester_gtx_sat_cnt #(
  parameter int W = 16,
  parameter bit SAT = 1'b1
) (
  input  logic         usrclk,
  input  logic         usrrst_n,
  input  logic         i_clr,
  input  logic [1:0]   i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W:0]   w_sum;
  logic [W-1:0] r_cnt;
  assign w_sum = {1'b0, r_cnt} + (W+1)'(i_inc);
  assign o_cnt = r_cnt;
  always_ff @(posedge usrclk or negedge usrrst_n)
    if (!usrrst_n) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : (SAT && w_sum[W]) ? '1 : w_sum[W-1:0];
endmodule

// File: rtl/tester_gtx_chk.sv
// tester_gtx_chk: RX checker for the GTX link pattern (IDLE fill + incrementing data bursts).
// Define TESTER_GTX_CHK_CAPTURE_EN to add err_exp/err_got/err_cap_vld first-error capture.
module tester_gtx_chk
  import tester_gtx_pkg::*;
#(
  parameter logic [15:0] IDLE = IDLE_WORD,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int LOCK_BURSTS = LOCK_BURSTS_DEF
) (
  input  logic        usrclk,
  input  logic        usrrst_n,
  input  logic        rx_aligned,
  input  logic        chk_en,
  input  logic        err_clr,
  input  logic [15:0] rxdata,
  input  logic [1:0]  rxchar,
  output logic        lock,
  output logic        word_err,
  output logic        len_err,
  output logic [15:0] err_cnt,
  output logic [31:0] burst_cnt
`ifdef TESTER_GTX_CHK_CAPTURE_EN
  ,
  output logic [15:0] err_exp,
  output logic [15:0] err_got,
  output logic        err_cap_vld
`endif
);
  localparam int WCW = $clog2(BURST_LEN + 1);
  localparam int GW = $clog2(LOCK_BURSTS + 1);
  gtx_st_t r_st;
  logic [15:0] r_d1, r_exp, r_alt;
  logic [1:0] r_k1;
  logic [WCW-1:0] r_wcnt;
  logic [GW-1:0] r_good;
  logic r_alt_v, r_first, r_lock, r_werr, r_lerr;
  logic w_act, w_idle, w_data, w_bad, w_live, w_cmp, w_chk, w_mis, w_full;
  logic w_werr, w_lerr, w_good;
  logic [1:0] w_inc_err;
  assign w_act = chk_en && rx_aligned;
  assign w_idle = r_k1 == K_IDLE && r_d1 == IDLE;
  assign w_data = r_k1 == K_DATA;
  assign w_bad = !w_idle && !w_data;
  assign w_live = r_st == ST_IDLE || r_st == ST_DATA;
  assign w_cmp = w_act && w_live && w_data;
  assign w_chk = w_cmp && !(r_st == ST_IDLE && r_first);
  // After a mismatch, also accept the successor of the old expectation so a single corrupted word costs one error.
  assign w_mis = r_d1 != r_exp && !(r_alt_v && r_d1 == r_alt);
  assign w_full = r_wcnt == WCW'(BURST_LEN);
  assign w_werr = (w_act && w_live && w_bad) || (w_chk && w_mis);
  assign w_lerr = w_act && r_st == ST_DATA && ((w_data && w_full) || (w_idle && !w_full));
  assign w_good = w_act && r_st == ST_DATA && w_idle && w_full;
  assign w_inc_err = {1'b0, w_werr} + {1'b0, w_lerr};
  assign lock = r_lock;
  assign word_err = r_werr;
  assign len_err = r_lerr;
  always_ff @(posedge usrclk or negedge usrrst_n)
    if (!usrrst_n) begin
      r_d1 <= '0;
      r_k1 <= '0;
      r_st <= ST_UNLOCK;
      r_exp <= '0;
      r_alt <= '0;
      r_alt_v <= 1'b0;
      r_first <= 1'b0;
      r_wcnt <= '0;
      r_good <= '0;
      r_lock <= 1'b0;
      r_werr <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_d1 <= rxdata;
      r_k1 <= rxchar;
      r_werr <= w_werr;
      r_lerr <= w_lerr;
      if (!w_act) begin
        r_st <= ST_UNLOCK;
        r_lock <= 1'b0;
        r_good <= '0;
        r_alt_v <= 1'b0;
      end else begin
        if (w_cmp) begin
          r_exp <= r_d1 + 16'd1;
          r_alt <= r_exp + 16'd1;
          r_alt_v <= w_chk && w_mis;
        end
        if (w_werr || w_lerr) begin
          r_lock <= 1'b0;
          r_good <= '0;
        end else if (w_good) begin
          r_good <= (r_good == GW'(LOCK_BURSTS)) ? r_good : r_good + GW'(1);
          if (r_good >= GW'(LOCK_BURSTS - 1)) r_lock <= 1'b1;
        end
        case (r_st)
          ST_UNLOCK: r_st <= ST_SYNC;
          ST_SYNC: if (w_idle) begin
            r_st <= ST_IDLE;
            r_first <= 1'b1;
          end
          ST_IDLE: if (w_data) begin
            r_st <= ST_DATA;
            r_wcnt <= WCW'(1);
            r_first <= 1'b0;
          end
          ST_DATA:
            if (w_data && w_full) r_st <= ST_SYNC;
            else if (w_data) r_wcnt <= r_wcnt + WCW'(1);
            else r_st <= w_idle ? ST_IDLE : ST_SYNC;
          default: r_st <= ST_UNLOCK;
        endcase
      end
    end
  tester_gtx_sat_cnt #(.W(16), .SAT(1'b1)) u_err_cnt (
    .usrclk(usrclk), .usrrst_n(usrrst_n), .i_clr(err_clr), .i_inc(w_inc_err), .o_cnt(err_cnt)
  );
  tester_gtx_sat_cnt #(.W(32), .SAT(1'b0)) u_burst_cnt (
    .usrclk(usrclk), .usrrst_n(usrrst_n), .i_clr(err_clr), .i_inc({1'b0, w_good}), .o_cnt(burst_cnt)
  );
`ifdef TESTER_GTX_CHK_CAPTURE_EN
  logic [15:0] r_cap_exp, r_cap_got;
  logic r_cap_vld;
  assign err_exp = r_cap_exp;
  assign err_got = r_cap_got;
  assign err_cap_vld = r_cap_vld;
  always_ff @(posedge usrclk or negedge usrrst_n)
    if (!usrrst_n) begin
      r_cap_exp <= '0;
      r_cap_got <= '0;
      r_cap_vld <= 1'b0;
    end else if (err_clr) r_cap_vld <= 1'b0;
    else if (w_werr && !r_cap_vld) begin
      r_cap_exp <= r_exp;
      r_cap_got <= r_d1;
      r_cap_vld <= 1'b1;
    end
`endif
endmodule

// File: doc/tester_gtx_chk.md
Name: tester_gtx_chk

Overview:
- Receive-side checker for the GTX link test pattern.
- Consumes decoded 16-bit words plus K-char flags from the GTX RX user interface, on the RX usrclk domain.
- The pattern is K-char IDLE fill, then bursts of BURST_LEN data words carrying a free-running incrementing 16-bit counter that continues across bursts.
- The block locks to the pattern, checks value continuity, burst length and IDLE integrity, and reports lock status, error counts and burst counts to status registers.

Parameters:
- IDLE, 16'h02bc, expected fill word; valid only with rxchar == 2'b01.
- BURST_LEN, 32, data words per burst.
- LOCK_BURSTS, 4, consecutive error-free bursts required to assert lock.

Ports:
- usrclk  input  1  RX user clock.
- usrrst_n  input  1  reset, asynchronous, active-low.
- rx_aligned  input  1  GTX byte-alignment status; 0 forces the UNLOCK state.
- chk_en  input  1  enables checking; 0 holds the FSM in UNLOCK and freezes the counters.
- err_clr  input  1  single-cycle pulse that clears err_cnt and burst_cnt.
- rxdata  input  16  received word.
- rxchar  input  2  per-byte K flags; bit 0 is the low byte.
- lock  output  1  pattern locked.
- word_err  output  1  one-cycle pulse per erroneous word.
- len_err  output  1  one-cycle pulse per wrong-length burst.
- err_cnt  output  16  error count; saturates at 16'hffff.
- burst_cnt  output  32  count of good bursts; wraps.

Behaviour:
- Reset values: all outputs 0; FSM in UNLOCK; internal exp_val 0, word counter 0, good-burst counter 0.
- Pipeline:
  - rxdata and rxchar are registered once (stage 1).
  - Classification and compare happen in stage 2.
  - word_err and len_err assert 2 cycles after the offending word is at the ports.
- Word classes:
  - IDLE: rxchar == 2'b01 and rxdata == IDLE.
  - DATA: rxchar == 2'b00.
  - BAD: anything else.
- FSM states: UNLOCK, SYNC, IDLE, DATA.
- UNLOCK:
  - Entered on reset, when chk_en == 0, or when rx_aligned == 0. This is evaluated every cycle and has priority over all other transitions.
  - Moves to SYNC when chk_en and rx_aligned are both 1.
- SYNC:
  - Waits for an IDLE word, then moves to IDLE.
  - No errors are counted in SYNC.
- IDLE:
  - IDLE word: stay.
  - DATA word: go to DATA, set word counter to 1.
  - If this is the first burst since SYNC, load exp_val = rxdata + 1 (no value check).
  - Otherwise compare rxdata against exp_val; a mismatch is a word error. In both cases exp_val = rxdata + 1, so the checker resyncs after a single error.
  - BAD word: word error, stay in IDLE.
- DATA:
  - DATA word: compare against exp_val; exp_val = rxdata + 1; increment the word counter.
  - If the word counter would exceed BURST_LEN: len_err, then go to SYNC.
  - IDLE word with word counter == BURST_LEN: burst good; burst_cnt += 1; go to IDLE.
  - IDLE word with word counter != BURST_LEN: len_err; go to IDLE.
  - BAD word: word error; go to SYNC.
- Arithmetic: exp_val arithmetic is modulo 2^16, so 16'hffff is followed by 16'h0000 without error.
- Errors:
  - Each word_err or len_err increments err_cnt (saturating).
  - Both in the same cycle increment err_cnt by 2, still saturating.
- Lock:
  - Set after LOCK_BURSTS consecutive good bursts.
  - Cleared on any word_err, any len_err, or entry to UNLOCK/SYNC.
  - Any error resets the good-burst counter to 0.
- err_clr:
  - Clears err_cnt and burst_cnt in the cycle after the pulse.
  - If an error arrives in the same cycle, clear wins; that error is lost.
  - err_clr does not affect the FSM or lock.
- Mid-operation reset: asynchronously returns everything to reset values.
- Counters freeze while chk_en == 0.

Optional Feature:
- Macro TESTER_GTX_CHK_CAPTURE_EN.
- When defined:
  - Adds outputs err_exp[15:0] and err_got[15:0].
  - These latch exp_val and rxdata at the first word error after reset or err_clr, and hold until the next err_clr.
  - Adds output err_cap_vld, set together with the capture.
- When not defined: the ports and logic are absent.

Decomposition:
- Shared package tester_gtx_pkg holds:
  - The IDLE constant 16'h02bc.
  - The K-flag encodings 2'b01 and 2'b00.
  - The FSM state enum.
  - Default BURST_LEN.
- The package is also usable by the generator.
- One natural sub-module: tester_gtx_sat_cnt, a parameterised-width counter with increment-by-0/1/2, saturate-or-wrap select, and synchronous clear.
- err_cnt and burst_cnt are both instances of tester_gtx_sat_cnt.

Test Plan:
- Clean pattern, 32-word bursts with values 0..31, 32..63, ... and 10 IDLEs between bursts:
  - lock rises after the 4th burst's closing IDLE;
  - err_cnt stays 0;
  - burst_cnt reaches 8 after 8 bursts.
- Wrap: bursts that cross 16'hfff0..16'h000f contain no error.
- Single corrupted word (value 16'h0025 replaced by 16'h00ff):
  - exactly one word_err pulse, 2 cycles later;
  - err_cnt = 1; lock drops;
  - the next value is accepted with no second error.
- Short burst of 31 words, then IDLE: one len_err; err_cnt = 1; burst_cnt does not increment.
- Long burst of 33 words: len_err on the 33rd word; FSM returns to SYNC; relock after 4 good bursts.
- rx_aligned deasserted mid-burst: lock is 0 the next cycle and no errors are counted.
- err_clr pulse when err_cnt = 5: err_cnt = 0 next cycle.
- With CAPTURE_EN: err_exp = 16'h0025, err_got = 16'h00ff.
